// File: rtl/tpu_host_driver_if.sv
// tpu_host_driver_if: host request/result bus plus TPU pin bundle for the host driver
interface tpu_host_driver_if;
  logic        start;
  logic [31:0] weights;
  logic [31:0] inputs;
  logic        busy;
  logic        result_valid;
  logic        timeout;
  logic [15:0] c00;
  logic [15:0] c01;
  logic [15:0] c10;
  logic [15:0] c11;
  logic [7:0]  tpu_data;
  logic        tpu_instr;
  logic [7:0]  tpu_out;
  logic        tpu_done;
  modport master (
    input  start, weights, inputs, tpu_out, tpu_done,
    output busy, result_valid, timeout, c00, c01, c10, c11, tpu_data, tpu_instr
  );
  modport slave (
    output start, weights, inputs, tpu_out, tpu_done,
    input  busy, result_valid, timeout, c00, c01, c10, c11, tpu_data, tpu_instr
  );
endinterface

// File: rtl/tpu_host_driver.sv
// tpu_host_driver: serialises 2x2 weights/inputs onto TPU pins and collects the four 16-bit results
module tpu_host_driver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst_n,
  tpu_host_driver_if.master io_bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, CAPTURE, RESP} state_t;
  state_t        r_state;
  logic [63:0]   r_shadow;
  logic [63:0]   r_buf;
  logic [63:0]   r_c;
  logic [3:0]    r_k;
  logic [2:0]    r_slot;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_valid;
  logic          r_timeout;
  logic [7:0]    r_data;
  logic          r_instr;
  logic [7:0]    w_byte;
  logic          w_tmo;
  assign w_byte = r_shadow[{r_k[2:0], 3'b000} +: 8];
  assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYCLES));
  assign io_bus.busy         = r_busy;
  assign io_bus.result_valid = r_valid;
  assign io_bus.timeout      = r_timeout;
  assign io_bus.c00          = r_c[15:0];
  assign io_bus.c01          = r_c[31:16];
  assign io_bus.c10          = r_c[47:32];
  assign io_bus.c11          = r_c[63:48];
  assign io_bus.tpu_data     = r_data;
  assign io_bus.tpu_instr    = r_instr;
  // Transaction FSM; byte 0 goes out on the start edge so busy/instr/w00 appear together,
  // and busy clears on the IDLE edge after RESP so result_valid is seen while still busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_buf     <= '0;
      r_c       <= '0;
      r_k       <= '0;
      r_slot    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= '0;
      r_instr   <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= io_bus.start;
          if (io_bus.start) begin
            r_shadow <= {io_bus.inputs, io_bus.weights};
            r_k      <= 4'd1;
            r_data   <= io_bus.weights[7:0];
            r_instr  <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          if (r_k == 4'd8) begin
            r_instr <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else begin
            r_data <= w_byte;
            r_k    <= r_k + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (io_bus.tpu_done) begin
            r_buf[7:0] <= io_bus.tpu_out;
            r_slot     <= 3'd1;
            r_cnt      <= '0;
            r_state    <= CAPTURE;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (io_bus.tpu_done) begin
            r_buf[{r_slot, 3'b000} +: 8] <= io_bus.tpu_out;
            r_slot <= r_slot + 3'd1;
            r_cnt  <= '0;
            if (r_slot == 3'd7) r_state <= RESP;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_c     <= r_buf;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_host_driver.sv
// tb_tpu_host_driver: directed tests of the TPU host driver against a scripted TPU pin model
module tb_tpu_host_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  tpu_host_driver_if bus();
  tpu_host_driver #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  // Starts a transaction and plays the TPU side: done begins at cycle 13 (5 after load),
  // optional gap of gap_len cycles before byte gap_at, optional stray start pulses while busy.
  task automatic drive_txn(input logic [31:0] w, input logic [31:0] x, input logic [7:0] base,
                           input int n_bytes, input int gap_at, input int gap_len, input bit stray,
                           output int v_at, output int n_v, output int t_at, output int n_t,
                           output int b_low, output int n_rise);
    logic prev;
    bus.weights = w;
    bus.inputs  = x;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    v_at = -1; n_v = 0; t_at = -1; n_t = 0; b_low = -1; n_rise = 0; prev = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      int p;
      int b;
      p = cyc - 13;
      b = (p < gap_at) ? p : ((p < gap_at + gap_len) ? -1 : p - gap_len);
      bus.tpu_done = (p >= 0) && (b >= 0) && (b < n_bytes);
      bus.tpu_out  = bus.tpu_done ? base + 8'(b) : 8'h00;
      bus.start    = stray && (cyc == 3 || cyc == 10 || cyc == 15);
      if (bus.result_valid) begin n_v++; if (v_at < 0) v_at = cyc; end
      if (bus.timeout) begin n_t++; if (t_at < 0) t_at = cyc; end
      if (!bus.busy && b_low < 0) b_low = cyc;
      if (bus.tpu_instr && !prev) n_rise++;
      prev = bus.tpu_instr;
      tick();
    end
    bus.tpu_done = 1'b0;
    bus.tpu_out  = 8'h00;
    bus.start    = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", bus.busy); else n_pass++;
    n_total++; if (bus.tpu_instr !== 1'b0) $display("FAIL reset_instr got %0h want 0", bus.tpu_instr); else n_pass++;
    n_total++; if (bus.tpu_data !== 8'h00) $display("FAIL reset_data got %0h want 0", bus.tpu_data); else n_pass++;
    n_total++; if ({bus.result_valid, bus.timeout} !== 2'b00) $display("FAIL reset_pulses got %0b want 00", {bus.result_valid, bus.timeout}); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h0) $display("FAIL reset_results got %0h want 0", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
  endtask
  task automatic test_load();
    bus.weights = 32'h04030201;
    bus.inputs  = 32'h08070605;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (bus.tpu_instr !== 1'b1) $display("FAIL load_instr[%0d] got %0h want 1", i, bus.tpu_instr); else n_pass++;
      n_total++; if (bus.tpu_data !== 8'(i + 1)) $display("FAIL load_data[%0d] got %0h want %0h", i, bus.tpu_data, 8'(i + 1)); else n_pass++;
      if (i == 0) begin
        n_total++; if (bus.busy !== 1'b1) $display("FAIL load_busy got %0h want 1", bus.busy); else n_pass++;
      end
      tick();
    end
    n_total++; if (bus.tpu_instr !== 1'b0) $display("FAIL load_instr_after got %0h want 0", bus.tpu_instr); else n_pass++;
    n_total++; if (bus.tpu_data !== 8'h00) $display("FAIL load_data_after got %0h want 0", bus.tpu_data); else n_pass++;
    apply_reset();
  endtask
  task automatic test_full();
    int v_at, n_v, t_at, n_t, b_low, n_rise;
    drive_txn(32'h04030201, 32'h08070605, 8'h11, 8, 8, 0, 1'b0, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (v_at !== 22) $display("FAIL full_valid_cycle got %0d want 22", v_at); else n_pass++;
    n_total++; if (n_v !== 1) $display("FAIL full_valid_count got %0d want 1", n_v); else n_pass++;
    n_total++; if (b_low !== 23) $display("FAIL full_busy_low got %0d want 23", b_low); else n_pass++;
    n_total++; if (n_t !== 0) $display("FAIL full_timeout got %0d want 0", n_t); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h1817_1615_1413_1211) $display("FAIL full_results got %0h want 1817161514131211", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
  endtask
  task automatic test_gapped();
    int v_at, n_v, t_at, n_t, b_low, n_rise;
    bus.tpu_out = 8'h00;
    apply_reset();
    drive_txn(32'h04030201, 32'h08070605, 8'h11, 9, 4, 3, 1'b0, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (v_at !== 25) $display("FAIL gap_valid_cycle got %0d want 25", v_at); else n_pass++;
    n_total++; if (n_v !== 1) $display("FAIL gap_valid_count got %0d want 1", n_v); else n_pass++;
    n_total++; if (b_low !== 26) $display("FAIL gap_busy_low got %0d want 26", b_low); else n_pass++;
    n_total++; if (n_t !== 0) $display("FAIL gap_timeout got %0d want 0", n_t); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h1817_1615_1413_1211) $display("FAIL gap_results got %0h want 1817161514131211", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
  endtask
  task automatic test_timeout_wait();
    int v_at, n_v, t_at, n_t, b_low, n_rise;
    drive_txn(32'hAAAAAAAA, 32'h55555555, 8'h00, 0, 8, 0, 1'b0, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (t_at !== 74) $display("FAIL tw_timeout_cycle got %0d want 74", t_at); else n_pass++;
    n_total++; if (n_t !== 1) $display("FAIL tw_timeout_count got %0d want 1", n_t); else n_pass++;
    n_total++; if (b_low !== 74) $display("FAIL tw_busy_low got %0d want 74", b_low); else n_pass++;
    n_total++; if (n_v !== 0) $display("FAIL tw_valid_count got %0d want 0", n_v); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h1817_1615_1413_1211) $display("FAIL tw_results got %0h want 1817161514131211", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
  endtask
  task automatic test_timeout_capture();
    int v_at, n_v, t_at, n_t, b_low, n_rise;
    drive_txn(32'h01010101, 32'h02020202, 8'h21, 3, 8, 0, 1'b0, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (t_at !== 81) $display("FAIL tc_timeout_cycle got %0d want 81", t_at); else n_pass++;
    n_total++; if (n_t !== 1) $display("FAIL tc_timeout_count got %0d want 1", n_t); else n_pass++;
    n_total++; if (n_v !== 0) $display("FAIL tc_valid_count got %0d want 0", n_v); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h1817_1615_1413_1211) $display("FAIL tc_results_held got %0h want 1817161514131211", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
    drive_txn(32'h01010101, 32'h02020202, 8'h31, 8, 8, 0, 1'b0, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (v_at !== 22) $display("FAIL tc_next_valid_cycle got %0d want 22", v_at); else n_pass++;
    n_total++; if (n_t !== 0) $display("FAIL tc_next_timeout got %0d want 0", n_t); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h3837_3635_3433_3231) $display("FAIL tc_next_results got %0h want 3837363534333231", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
  endtask
  task automatic test_reset_mid_load();
    bus.weights = 32'h44332211;
    bus.inputs  = 32'h88776655;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    n_total++; if ({bus.tpu_instr, bus.tpu_data} !== {1'b1, 8'h44}) $display("FAIL rml_cycle4 got %0h want 144", {bus.tpu_instr, bus.tpu_data}); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if ({bus.busy, bus.tpu_instr, bus.tpu_data} !== 10'h0) $display("FAIL rml_outputs got %0h want 0", {bus.busy, bus.tpu_instr, bus.tpu_data}); else n_pass++;
    n_total++; if ({bus.c11, bus.c10, bus.c01, bus.c00} !== 64'h0) $display("FAIL rml_results got %0h want 0", {bus.c11, bus.c10, bus.c01, bus.c00}); else n_pass++;
    rst_n = 1'b1;
    tick();
    tick();
    n_total++; if ({bus.busy, bus.tpu_instr} !== 2'b00) $display("FAIL rml_stays_idle got %0b want 00", {bus.busy, bus.tpu_instr}); else n_pass++;
  endtask
  task automatic test_start_rules();
    int v_at, n_v, t_at, n_t, b_low, n_rise;
    drive_txn(32'h00000000, 32'h00000000, 8'h41, 8, 8, 0, 1'b1, v_at, n_v, t_at, n_t, b_low, n_rise);
    n_total++; if (n_rise !== 1) $display("FAIL sr_load_count got %0d want 1", n_rise); else n_pass++;
    n_total++; if (n_v !== 1) $display("FAIL sr_valid_count got %0d want 1", n_v); else n_pass++;
    n_total++; if (v_at !== 22) $display("FAIL sr_valid_cycle got %0d want 22", v_at); else n_pass++;
    n_total++; if ({bus.c11, bus.c00} !== 32'h4847_4241) $display("FAIL sr_results got %0h want 48474241", {bus.c11, bus.c00}); else n_pass++;
  endtask
  task automatic test_back_to_back();
    int n_rise, n_v, n_low;
    logic prev;
    n_rise = 0; n_v = 0; n_low = 0; prev = 1'b0;
    bus.tpu_done = 1'b1;
    bus.tpu_out  = 8'hA5;
    bus.start    = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 54; cyc++) begin
      if (bus.tpu_instr && !prev) n_rise++;
      prev = bus.tpu_instr;
      if (bus.result_valid) n_v++;
      if (!bus.busy) n_low++;
      if (cyc == 54) bus.start = 1'b0;
      tick();
    end
    bus.tpu_done = 1'b0;
    n_total++; if (n_rise !== 3) $display("FAIL b2b_load_count got %0d want 3", n_rise); else n_pass++;
    n_total++; if (n_v !== 3) $display("FAIL b2b_valid_count got %0d want 3", n_v); else n_pass++;
    n_total++; if (n_low !== 0) $display("FAIL b2b_busy_gaps got %0d want 0", n_low); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_end got %0h want 0", bus.busy); else n_pass++;
    n_total++; if ({bus.c11, bus.c00} !== 32'hA5A5_A5A5) $display("FAIL b2b_results got %0h want a5a5a5a5", {bus.c11, bus.c00}); else n_pass++;
  endtask
  initial begin
    bus.start    = 1'b0;
    bus.weights  = '0;
    bus.inputs   = '0;
    bus.tpu_out  = '0;
    bus.tpu_done = 1'b0;
    test_reset();
    test_load();
    test_full();
    test_gapped();
    test_timeout_wait();
    test_timeout_capture();
    test_reset_mid_load();
    test_start_rules();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
